// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and issue bundle of the ALU reservation station.
// master = reorder-buffer/dispatch side, slave = reservation station.
interface reservation_station_if #(
    parameter int TAG_W = 3
);
    logic [4:0]       op_in;
    logic [31:0]      value1_in;
    logic [31:0]      value2_in;
    logic [TAG_W-1:0] query1_in;
    logic [TAG_W-1:0] query2_in;
    logic [TAG_W-1:0] target_in;
    logic [31:0]      imm_in;
    logic [TAG_W-1:0] alu_num;
    logic [31:0]      alu_value;
    logic [TAG_W-1:0] mem_num;
    logic [31:0]      mem_value;
    logic             rs_full;
    logic [4:0]       alu_op_out;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_imm;
    logic [TAG_W-1:0] alu_tag_out;

    modport master (
        output op_in, value1_in, value2_in, query1_in, query2_in, target_in, imm_in,
        output alu_num, alu_value, mem_num, mem_value,
        input  rs_full, alu_op_out, alu_a, alu_b, alu_imm, alu_tag_out
    );

    modport slave (
        input  op_in, value1_in, value2_in, query1_in, query2_in, target_in, imm_in,
        input  alu_num, alu_value, mem_num, mem_value,
        output rs_full, alu_op_out, alu_a, alu_b, alu_imm, alu_tag_out
    );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ops until operands arrive, issues oldest ready one.
// Optional macro RS_WAKEUP_BYPASS_EN lets an entry woken this cycle issue on the same edge.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3,
    parameter int AGE_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    reservation_station_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [4:0] OP_NONE  = 5'b11111;
    localparam logic [4:0] OP_LS_LO = 5'b10010;
    localparam logic [4:0] OP_LS_HI = 5'b11001;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       op;
        logic [31:0]      v1;
        tag_t             q1;
        logic [31:0]      v2;
        tag_t             q2;
        logic [31:0]      imm;
        tag_t             tag;
        logic [AGE_W-1:0] age;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [4:0]       aluOp_q;
    logic [31:0]      aluA_q;
    logic [31:0]      aluB_q;
    logic [31:0]      aluImm_q;
    tag_t             aluTag_q;
    logic             rsFull_q;
    logic             rsFull_d;

    logic             eligible;
    logic             winFound;
    idx_t             winIdx;
    logic [AGE_W-1:0] winAge;
    logic [31:0]      issueA;
    logic [31:0]      issueB;
    logic             dispAccept;
    logic             freeFound;
    idx_t             freeIdx;
    logic [IDX_W:0]   occCount;

    function automatic logic tagHit(input tag_t q, input tag_t num);
        return (q != '0) && (q == num);
    endfunction

    // ALU bus wins when both broadcasts carry the awaited tag.
    function automatic logic [31:0] wakeVal(input logic [31:0] v, input tag_t q,
                                            input tag_t aN, input logic [31:0] aV,
                                            input tag_t mN, input logic [31:0] mV);
        if (tagHit(q, aN)) return aV;
        if (tagHit(q, mN)) return mV;
        return v;
    endfunction

    function automatic tag_t wakeQ(input tag_t q, input tag_t aN, input tag_t mN);
        return (tagHit(q, aN) || tagHit(q, mN)) ? '0 : q;
    endfunction

    always_comb begin
        eligible = 1'b0;
        winFound = 1'b0;
        winIdx   = '0;
        winAge   = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            eligible = entry_q[i].valid
                     && (wakeQ(entry_q[i].q1, bus.alu_num, bus.mem_num) == '0)
                     && (wakeQ(entry_q[i].q2, bus.alu_num, bus.mem_num) == '0);
`else
            eligible = entry_q[i].valid && (entry_q[i].q1 == '0) && (entry_q[i].q2 == '0);
`endif
            // Strictly greater keeps the lowest index on an age tie.
            if (eligible && (!winFound || entry_q[i].age > winAge)) begin
                winFound = 1'b1;
                winIdx   = idx_t'(i);
                winAge   = entry_q[i].age;
            end
        end
        issueA = wakeVal(entry_q[winIdx].v1, entry_q[winIdx].q1,
                         bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
        issueB = wakeVal(entry_q[winIdx].v2, entry_q[winIdx].q2,
                         bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
    end

    always_comb begin
        dispAccept = (bus.op_in != OP_NONE)
                   && !((bus.op_in >= OP_LS_LO) && (bus.op_in <= OP_LS_HI));
        freeFound = 1'b0;
        freeIdx   = '0;
        // Free slots come from registered state, so a slot issued this edge is not reused yet.
        for (int i = 0; i < DEPTH; i++) begin
            if (!freeFound && !entry_q[i].valid) begin
                freeFound = 1'b1;
                freeIdx   = idx_t'(i);
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].valid) begin
                entry_d[i].v1 = wakeVal(entry_q[i].v1, entry_q[i].q1,
                                        bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
                entry_d[i].q1 = wakeQ(entry_q[i].q1, bus.alu_num, bus.mem_num);
                entry_d[i].v2 = wakeVal(entry_q[i].v2, entry_q[i].q2,
                                        bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
                entry_d[i].q2 = wakeQ(entry_q[i].q2, bus.alu_num, bus.mem_num);
                if (entry_q[i].age != AGE_MAX) begin
                    entry_d[i].age = entry_q[i].age + 1'b1;
                end
            end
        end

        if (winFound) begin
            entry_d[winIdx].valid = 1'b0;
        end

        if (dispAccept && freeFound) begin
            entry_d[freeIdx] = '{
                valid: 1'b1,
                op:    bus.op_in,
                v1:    wakeVal(bus.value1_in, bus.query1_in,
                               bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value),
                q1:    wakeQ(bus.query1_in, bus.alu_num, bus.mem_num),
                v2:    wakeVal(bus.value2_in, bus.query2_in,
                               bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value),
                q2:    wakeQ(bus.query2_in, bus.alu_num, bus.mem_num),
                imm:   bus.imm_in,
                tag:   bus.target_in,
                age:   '0
            };
        end

        occCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occCount = occCount + (IDX_W+1)'(entry_d[i].valid);
        end
        rsFull_d = (occCount >= (IDX_W+1)'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            aluOp_q  <= OP_NONE;
            aluA_q   <= '0;
            aluB_q   <= '0;
            aluImm_q <= '0;
            aluTag_q <= '0;
            rsFull_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            rsFull_q <= rsFull_d;
            // Data outputs hold through bubbles; only op and tag mark the bubble.
            if (winFound) begin
                aluOp_q  <= entry_q[winIdx].op;
                aluA_q   <= issueA;
                aluB_q   <= issueB;
                aluImm_q <= entry_q[winIdx].imm;
                aluTag_q <= entry_q[winIdx].tag;
            end else begin
                aluOp_q  <= OP_NONE;
                aluTag_q <= '0;
            end
        end
    end

    assign bus.rs_full     = rsFull_q;
    assign bus.alu_op_out  = aluOp_q;
    assign bus.alu_a       = aluA_q;
    assign bus.alu_b       = aluB_q;
    assign bus.alu_imm     = aluImm_q;
    assign bus.alu_tag_out = aluTag_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station (DEPTH=4, TAG_W=3, default build).
// Each vector is one clock: inputs driven on negedge, outputs compared 1 time unit after posedge.
module tb_reservation_station;
    localparam logic [4:0] NOP = 5'b11111;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] v1;
        logic [2:0]  q1;
        logic [31:0] v2;
        logic [2:0]  q2;
        logic [2:0]  tgt;
        logic [31:0] imm;
        logic [2:0]  aN;
        logic [31:0] aV;
        logic [2:0]  mN;
        logic [31:0] mV;
        logic [4:0]  eOp;
        logic [31:0] eA;
        logic [31:0] eB;
        logic [31:0] eImm;
        logic [2:0]  eTag;
        logic        eFull;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];

    reservation_station_if #(.TAG_W(3)) bus ();

    reservation_station #(.DEPTH(4), .TAG_W(3), .AGE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one clock of stimulus plus the outputs expected right after its edge.
    task automatic addVec(input string name, input logic [4:0] op, input logic [31:0] v1,
                          input logic [2:0] q1, input logic [31:0] v2, input logic [2:0] q2,
                          input logic [2:0] tgt, input logic [31:0] imm,
                          input logic [2:0] aN, input logic [31:0] aV,
                          input logic [2:0] mN, input logic [31:0] mV,
                          input logic [4:0] eOp, input logic [31:0] eA, input logic [31:0] eB,
                          input logic [31:0] eImm, input logic [2:0] eTag, input logic eFull);
        vec_t v;
        v = '{name, op, v1, q1, v2, q2, tgt, imm, aN, aV, mN, mV, eOp, eA, eB, eImm, eTag, eFull};
        vecs.push_back(v);
    endtask

    task automatic driveIdle();
        bus.op_in     = NOP;
        bus.value1_in = '0;
        bus.value2_in = '0;
        bus.query1_in = '0;
        bus.query2_in = '0;
        bus.target_in = '0;
        bus.imm_in    = '0;
        bus.alu_num   = '0;
        bus.alu_value = '0;
        bus.mem_num   = '0;
        bus.mem_value = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.op_in     = v.op;
        bus.value1_in = v.v1;
        bus.value2_in = v.v2;
        bus.query1_in = v.q1;
        bus.query2_in = v.q2;
        bus.target_in = v.tgt;
        bus.imm_in    = v.imm;
        bus.alu_num   = v.aN;
        bus.alu_value = v.aV;
        bus.mem_num   = v.mN;
        bus.mem_value = v.mV;
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [4:0] eOp, input logic [31:0] eA,
                               input logic [31:0] eB, input logic [31:0] eImm,
                               input logic [2:0] eTag, input logic eFull);
        checkValue({name, ".op"},   32'(bus.alu_op_out),  32'(eOp));
        checkValue({name, ".a"},    bus.alu_a,            eA);
        checkValue({name, ".b"},    bus.alu_b,            eB);
        checkValue({name, ".imm"},  bus.alu_imm,          eImm);
        checkValue({name, ".tag"},  32'(bus.alu_tag_out), 32'(eTag));
        checkValue({name, ".full"}, 32'(bus.rs_full),     32'(eFull));
    endtask

    task automatic runVectors();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].eOp, vecs[i].eA, vecs[i].eB,
                        vecs[i].eImm, vecs[i].eTag, vecs[i].eFull);
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        driveIdle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #11;
        checkOutput("reset", NOP, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        //      name           op     v1        q1 v2       q2 tgt imm     aN aV       mN mV        eOp    eA        eB      eImm    eTag eFull
        addVec("add_disp",     5'h00, 32'h5,    0, 32'h7,   0, 2, 32'h11,  0, 32'h0,   0, 32'h0,    NOP,   32'h0,    32'h0,  32'h0,  0, 0);
        addVec("add_issue",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h00, 32'h5,    32'h7,  32'h11, 2, 0);
        addVec("add_bubble",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h5,    32'h7,  32'h11, 0, 0);
        addVec("sub_disp",     5'h01, 32'hDEAD, 3, 32'h1,   0, 4, 32'h22,  0, 32'h0,   0, 32'h0,    NOP,   32'h5,    32'h7,  32'h11, 0, 0);
        addVec("sub_wait",     NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h5,    32'h7,  32'h11, 0, 0);
        addVec("sub_wake",     NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   3, 32'hA,   0, 32'h0,    NOP,   32'h5,    32'h7,  32'h11, 0, 0);
        addVec("sub_issue",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h01, 32'hA,    32'h1,  32'h22, 4, 0);
        addVec("sub_bubble",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'hA,    32'h1,  32'h22, 0, 0);
        addVec("dual_disp",    5'h02, 32'h0,    5, 32'h0,   6, 3, 32'h33,  0, 32'h0,   0, 32'h0,    NOP,   32'hA,    32'h1,  32'h22, 0, 0);
        addVec("dual_wake",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   6, 32'h20,  5, 32'h100,  NOP,   32'hA,    32'h1,  32'h22, 0, 0);
        addVec("dual_issue",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h02, 32'h100,  32'h20, 32'h33, 3, 0);
        addVec("fwd_disp",     5'h03, 32'h0,    7, 32'h4,   0, 5, 32'h44,  7, 32'h9,   7, 32'h77,   NOP,   32'h100,  32'h20, 32'h33, 0, 0);
        addVec("fwd_issue",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h03, 32'h9,    32'h4,  32'h44, 5, 0);
        addVec("ls_lo_drop",   5'h12, 32'h1,    0, 32'h1,   0, 6, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h9,    32'h4,  32'h44, 0, 0);
        addVec("ls_hi_drop",   5'h19, 32'h1,    0, 32'h1,   0, 7, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h9,    32'h4,  32'h44, 0, 0);
        addVec("below_ls",     5'h11, 32'h1,    0, 32'h2,   0, 6, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h9,    32'h4,  32'h44, 0, 0);
        addVec("below_issue",  NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h11, 32'h1,    32'h2,  32'h0,  6, 0);
        addVec("above_ls",     5'h1A, 32'h3,    0, 32'h4,   0, 7, 32'h55,  0, 32'h0,   0, 32'h0,    NOP,   32'h1,    32'h2,  32'h0,  0, 0);
        addVec("above_issue",  NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h1A, 32'h3,    32'h4,  32'h55, 7, 0);
        addVec("full_d1",      5'h04, 32'h0,    5, 32'h0,   0, 1, 32'h1,   0, 32'h0,   0, 32'h0,    NOP,   32'h3,    32'h4,  32'h55, 0, 0);
        addVec("full_d2",      5'h05, 32'h0,    6, 32'h0,   0, 2, 32'h2,   0, 32'h0,   0, 32'h0,    NOP,   32'h3,    32'h4,  32'h55, 0, 0);
        addVec("full_d3",      5'h06, 32'h0,    7, 32'h0,   0, 3, 32'h3,   0, 32'h0,   0, 32'h0,    NOP,   32'h3,    32'h4,  32'h55, 0, 1);
        addVec("full_wake",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   5, 32'h50,   NOP,   32'h3,    32'h4,  32'h55, 0, 1);
        addVec("full_drop",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h04, 32'h50,   32'h0,  32'h1,  1, 0);
        addVec("age_wake",     NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   6, 32'h60,  7, 32'h70,   NOP,   32'h50,   32'h0,  32'h1,  0, 0);
        addVec("age_old",      NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h05, 32'h60,   32'h0,  32'h2,  2, 0);
        addVec("age_new",      NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h06, 32'h70,   32'h0,  32'h3,  3, 0);
        addVec("age_bubble",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h70,   32'h0,  32'h3,  0, 0);
        addVec("ord_d1",       5'h07, 32'h0,    5, 32'h0,   0, 1, 32'h7,   0, 32'h0,   0, 32'h0,    NOP,   32'h70,   32'h0,  32'h3,  0, 0);
        addVec("ord_d2",       5'h08, 32'h0,    6, 32'h0,   0, 2, 32'h8,   0, 32'h0,   0, 32'h0,    NOP,   32'h70,   32'h0,  32'h3,  0, 0);
        addVec("ord_wake0",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   5, 32'hA,    NOP,   32'h70,   32'h0,  32'h3,  0, 0);
        addVec("ord_issue0",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h07, 32'hA,    32'h0,  32'h7,  1, 0);
        addVec("ord_d3",       5'h09, 32'h0,    7, 32'h0,   0, 3, 32'h9,   0, 32'h0,   0, 32'h0,    NOP,   32'hA,    32'h0,  32'h7,  0, 0);
        addVec("ord_wake",     NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   6, 32'hB6,  7, 32'hC7,   NOP,   32'hA,    32'h0,  32'h7,  0, 0);
        addVec("ord_older",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h08, 32'hB6,   32'h0,  32'h8,  2, 0);
        addVec("ord_newer",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h09, 32'hC7,   32'h0,  32'h9,  3, 0);
        addVec("ord_bubble",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'hC7,   32'h0,  32'h9,  0, 0);
        addVec("rst_d1",       5'h0B, 32'h0,    5, 32'h0,   0, 1, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'hC7,   32'h0,  32'h9,  0, 0);
        addVec("rst_d2",       5'h0C, 32'h0,    6, 32'h0,   0, 2, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'hC7,   32'h0,  32'h9,  0, 0);
        addVec("rst_d3",       5'h0D, 32'h0,    7, 32'h0,   0, 3, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'hC7,   32'h0,  32'h9,  0, 1);
        runVectors();

        // Asynchronous reset in the middle of a low clock phase with three waiting entries.
        @(negedge clk);
        driveIdle();
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst", NOP, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_held", NOP, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Broadcasting the discarded entries' tags must not resurrect them.
        addVec("post_wake1",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   5, 32'h1,   6, 32'h2,    NOP,   32'h0,    32'h0,  32'h0,  0, 0);
        addVec("post_wake2",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   7, 32'h3,   0, 32'h0,    NOP,   32'h0,    32'h0,  32'h0,  0, 0);
        addVec("post_idle",    NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h0,    32'h0,  32'h0,  0, 0);
        addVec("post_disp",    5'h0A, 32'h123,  0, 32'h456, 0, 4, 32'h66,  0, 32'h0,   0, 32'h0,    NOP,   32'h0,    32'h0,  32'h0,  0, 0);
        addVec("post_issue",   NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    5'h0A, 32'h123,  32'h456, 32'h66, 4, 0);
        addVec("post_bubble",  NOP,   32'h0,    0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h0,    NOP,   32'h123,  32'h456, 32'h66, 0, 0);
        runVectors();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
